// File: rtl/oflow_calc_iou_multi_if.sv
// ---------------------------------------------------------------------------
// oflow_calc_iou_multi_if
// Request/response bundle for the multi-candidate IoU engine.
//   master : requester (drives start, boxes, enables, threshold; reads results)
//   slave  : IoU engine
// Signals:
//   start                        request pulse
//   bbox_position_frame_k        {X_TL,Y_TL,X_BR,Y_BR} of the current box
//   bbox_position_frame_history  NUM_HIST packed history boxes, entry 0 at LSBs
//   hist_valid                   per-candidate enable
//   iou_thresh                   minimum IoU for best_found
//   busy, valid_iou, iou, iou_idx, done, best_iou, best_idx, best_found
// ---------------------------------------------------------------------------
interface oflow_calc_iou_multi_if #(
  parameter int COORD_W  = 11,
  parameter int NUM_HIST = 8,
  parameter int IOU_W    = 12
);
  localparam int IDX_W = $clog2(NUM_HIST) + 1;

  logic                           start;
  logic [4*COORD_W-1:0]           bbox_position_frame_k;
  logic [NUM_HIST*4*COORD_W-1:0]  bbox_position_frame_history;
  logic [NUM_HIST-1:0]            hist_valid;
  logic [IOU_W-1:0]               iou_thresh;
  logic                           busy;
  logic                           valid_iou;
  logic [IOU_W-1:0]               iou;
  logic [IDX_W-1:0]               iou_idx;
  logic                           done;
  logic [IOU_W-1:0]               best_iou;
  logic [IDX_W-1:0]               best_idx;
  logic                           best_found;

  modport master (
    output start, bbox_position_frame_k, bbox_position_frame_history,
           hist_valid, iou_thresh,
    input  busy, valid_iou, iou, iou_idx, done, best_iou, best_idx, best_found
  );

  modport slave (
    input  start, bbox_position_frame_k, bbox_position_frame_history,
           hist_valid, iou_thresh,
    output busy, valid_iou, iou, iou_idx, done, best_iou, best_idx, best_found
  );
endinterface

// File: rtl/oflow_calc_iou_multi.sv
// ---------------------------------------------------------------------------
// oflow_calc_iou_multi
// Compares one current-frame bbox against NUM_HIST history bboxes, one
// candidate at a time, streaming one IoU per enabled candidate and reporting
// the best match gated by a threshold. IoU = iou / 2^IOU_W, 1.0 saturates to
// all-ones. Each enabled candidate takes CALC + IOU_W divide steps + EMIT;
// a disabled candidate takes a single CALC cycle.
// Ports:
//   clk      rising-edge clock
//   reset_N  asynchronous active-low reset (aborts a request, no done)
//   bus      oflow_calc_iou_multi_if.slave (request inputs, result outputs)
// ---------------------------------------------------------------------------
module oflow_calc_iou_multi #(
  parameter int COORD_W  = 11,
  parameter int NUM_HIST = 8,
  parameter int IOU_W    = 12
) (
  input  logic                   clk,
  input  logic                   reset_N,
  oflow_calc_iou_multi_if.slave  bus
);

  localparam int ENT_W  = 4 * COORD_W;
  localparam int IDX_W  = $clog2(NUM_HIST) + 1;
  localparam int AREA_W = 2 * COORD_W;
  localparam int UNI_W  = AREA_W + 1;
  localparam int CNT_W  = $clog2(IOU_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HIST - 1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_DIV, S_EMIT, S_DONE} state_t;

  // Non-negative extent between two coordinates; inverted pairs give 0.
  function automatic logic [COORD_W-1:0] span(input logic [COORD_W-1:0] lo,
                                              input logic [COORD_W-1:0] hi);
    return (hi > lo) ? (hi - lo) : '0;
  endfunction

  function automatic logic [COORD_W-1:0] cmax(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [COORD_W-1:0] cmin(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // One restoring-division step: returns {quotient bit, new remainder}.
  // The remainder never exceeds uni, so doubling fits in UNI_W+1 bits.
  function automatic logic [UNI_W:0] div_step(input logic [UNI_W-1:0] rem,
                                               input logic [UNI_W-1:0] uni);
    logic [UNI_W:0] rem2;
    rem2 = {rem, 1'b0};
    if (rem2 >= {1'b0, uni}) return {1'b1, UNI_W'(rem2 - {1'b0, uni})};
    else                     return {1'b0, rem2[UNI_W-1:0]};
  endfunction

  // Empty union reads as 0; full overlap saturates to all-ones since
  // 2^IOU_W is not representable.
  function automatic logic [IOU_W-1:0] sat_iou(input logic [AREA_W-1:0] inter,
                                               input logic [UNI_W-1:0]  uni,
                                               input logic [IOU_W-1:0]  quo);
    if (uni == '0)                  return '0;
    else if (UNI_W'(inter) == uni)  return '1;
    else                            return quo;
  endfunction

  // Latched request (data, not reset)
  logic [ENT_W-1:0]          r_box_k;
  logic [NUM_HIST*ENT_W-1:0] r_hist;
  logic [NUM_HIST-1:0]       r_hist_valid;
  logic [IOU_W-1:0]          r_thresh;
  // Per-candidate arithmetic (data, not reset)
  logic [AREA_W-1:0]         r_inter;
  logic [UNI_W-1:0]          r_uni;
  logic [UNI_W-1:0]          r_rem;
  logic [IOU_W-1:0]          r_quo;
  // Control and outputs
  state_t                    r_state;
  logic [IDX_W-1:0]          r_idx;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_any;
  logic                      r_busy;
  logic                      r_valid_iou;
  logic [IOU_W-1:0]          r_iou;
  logic [IDX_W-1:0]          r_iou_idx;
  logic                      r_done;
  logic [IOU_W-1:0]          r_best_iou;
  logic [IDX_W-1:0]          r_best_idx;
  logic                      r_best_found;

  logic [ENT_W-1:0]          w_sel_box;
  logic                      w_sel_en;
  logic [COORD_W-1:0]        w_k_xtl, w_k_ytl, w_k_xbr, w_k_ybr;
  logic [COORD_W-1:0]        w_h_xtl, w_h_ytl, w_h_xbr, w_h_ybr;
  logic [AREA_W-1:0]         w_area_k, w_area_h, w_inter;
  logic [COORD_W-1:0]        w_ix, w_iy;
  logic [UNI_W-1:0]          w_uni;
  logic [UNI_W:0]            w_step;
  logic [IOU_W-1:0]          w_iou_final;

  always_comb begin
    w_sel_box = '0;
    w_sel_en  = 1'b0;
    for (int i = 0; i < NUM_HIST; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_box = r_hist[i*ENT_W +: ENT_W];
        w_sel_en  = r_hist_valid[i];
      end
    end
  end

  assign w_k_xtl = r_box_k[4*COORD_W-1 -: COORD_W];
  assign w_k_ytl = r_box_k[3*COORD_W-1 -: COORD_W];
  assign w_k_xbr = r_box_k[2*COORD_W-1 -: COORD_W];
  assign w_k_ybr = r_box_k[COORD_W-1:0];
  assign w_h_xtl = w_sel_box[4*COORD_W-1 -: COORD_W];
  assign w_h_ytl = w_sel_box[3*COORD_W-1 -: COORD_W];
  assign w_h_xbr = w_sel_box[2*COORD_W-1 -: COORD_W];
  assign w_h_ybr = w_sel_box[COORD_W-1:0];

  assign w_area_k = AREA_W'(span(w_k_xtl, w_k_xbr)) * AREA_W'(span(w_k_ytl, w_k_ybr));
  assign w_area_h = AREA_W'(span(w_h_xtl, w_h_xbr)) * AREA_W'(span(w_h_ytl, w_h_ybr));
  assign w_ix     = span(cmax(w_k_xtl, w_h_xtl), cmin(w_k_xbr, w_h_xbr));
  assign w_iy     = span(cmax(w_k_ytl, w_h_ytl), cmin(w_k_ybr, w_h_ybr));
  assign w_inter  = AREA_W'(w_ix) * AREA_W'(w_iy);
  // inter <= min(area_k, area_h), so the union cannot go negative.
  assign w_uni    = UNI_W'(w_area_k) + UNI_W'(w_area_h) - UNI_W'(w_inter);

  assign w_step      = div_step(r_rem, r_uni);
  assign w_iou_final = sat_iou(r_inter, r_uni, r_quo);

  // Request latch and divider datapath
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.start) begin
      r_box_k      <= bus.bbox_position_frame_k;
      r_hist       <= bus.bbox_position_frame_history;
      r_hist_valid <= bus.hist_valid;
      r_thresh     <= bus.iou_thresh;
    end
    if (r_state == S_CALC && w_sel_en) begin
      r_inter <= w_inter;
      r_uni   <= w_uni;
      r_rem   <= UNI_W'(w_inter);
      r_quo   <= '0;
    end
    if (r_state == S_DIV) begin
      r_quo <= {r_quo[IOU_W-2:0], w_step[UNI_W]};
      r_rem <= w_step[UNI_W-1:0];
    end
  end

  // Sequencer and registered outputs
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_any        <= 1'b0;
      r_busy       <= 1'b0;
      r_valid_iou  <= 1'b0;
      r_iou        <= '0;
      r_iou_idx    <= '0;
      r_done       <= 1'b0;
      r_best_iou   <= '0;
      r_best_idx   <= '0;
      r_best_found <= 1'b0;
    end else begin
      r_valid_iou <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy       <= 1'b1;
            r_best_iou   <= '0;
            r_best_idx   <= '0;
            r_best_found <= 1'b0;
            r_any        <= 1'b0;
            r_idx        <= '0;
            r_state      <= S_CALC;
          end
        end
        S_CALC: begin
          if (w_sel_en) begin
            r_cnt   <= '0;
            r_state <= S_DIV;
          end else if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(IOU_W - 1)) r_state <= S_EMIT;
        end
        S_EMIT: begin
          r_valid_iou <= 1'b1;
          r_iou       <= w_iou_final;
          r_iou_idx   <= r_idx;
          r_any       <= 1'b1;
          // Strict compare keeps the lower index on ties.
          if (!r_any || w_iou_final > r_best_iou) begin
            r_best_iou <= w_iou_final;
            r_best_idx <= r_idx;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_CALC;
          end
        end
        S_DONE: begin
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_best_found <= r_any && (r_best_iou >= r_thresh);
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.valid_iou  = r_valid_iou;
  assign bus.iou        = r_iou;
  assign bus.iou_idx    = r_iou_idx;
  assign bus.done       = r_done;
  assign bus.best_iou   = r_best_iou;
  assign bus.best_idx   = r_best_idx;
  assign bus.best_found = r_best_found;

endmodule
